// File: rtl/debug_regs_bank.sv
// debug_regs_bank
// Wishbone-slave debug register bank: NUM_REGS byte-writable 32-bit scratch
// registers plus a system page (write locks, free-running cycle counter,
// accepted-write counter, sticky protection-error flag). Each accepted
// request is held for ACK_WAIT wait cycles before being committed and acked;
// dropping cyc/stb while waiting abandons the request with no side effects.
//
// Ports:
//   wb_clk_i   bus clock, all state changes on its rising edge
//   wb_rstn_i  asynchronous active-low reset
//   wbs_cyc_i  bus cycle
//   wbs_stb_i  strobe
//   wbs_we_i   1 = write
//   wbs_sel_i  byte lane enables
//   wbs_dat_i  write data
//   wbs_adr_i  byte address (only the page bit and index bits are decoded)
//   wbs_ack_o  single-cycle acknowledge
//   wbs_dat_o  read data, 0 whenever ack is low
module debug_regs_bank #(
    parameter int NUM_REGS = 4,
    parameter int ACK_WAIT = 0,
    parameter int ADDR_LSB = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    localparam int IDXW = $clog2(NUM_REGS);
    localparam logic [2:0] WAIT_INIT = 3'(ACK_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [2:0]        wcnt_q, wcnt_d;

    // Request captured when it is accepted.
    logic              pg_q;
    logic [IDXW-1:0]   idx_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [31:0]       wdat_q;

    logic [31:0]       regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] lock_q;
    logic [31:0]       cycles_q;
    logic [15:0]       wrcnt_q;
    logic              err_q;

    logic              ack_q;
    logic [31:0]       rdata_q;

    logic              req;
    logic              accept;
    logic              commit;
    logic              wr_commit;
    logic [3:0]        sys_idx;
    logic [31:0]       wmask;
    logic [31:0]       wdata_m;
    logic [31:0]       rd_val;
    logic              unused_adr;

    assign req        = wbs_cyc_i & wbs_stb_i;
    // ack is registered one cycle behind the ACK state, so IDLE must also
    // refuse a request while the previous ack is still on the bus.
    assign accept     = (state_q == S_IDLE) & req & ~ack_q;
    assign unused_adr = ^wbs_adr_i;

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of every other register.
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wcnt_d  = WAIT_INIT;
                    state_d = (ACK_WAIT == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;              // master withdrew: abort
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                    if (wcnt_q == 3'd1) state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: the ACK state is the commit cycle; its closing edge
    // applies write effects, captures read data and raises ack.
    always_comb begin
        commit    = (state_q == S_ACK);
        wr_commit = commit & we_q;
    end

    // Request capture.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            pg_q   <= 1'b0;
            idx_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            wdat_q <= '0;
        end else if (accept) begin
            pg_q   <= wbs_adr_i[ADDR_LSB+IDXW];
            idx_q  <= wbs_adr_i[ADDR_LSB +: IDXW];
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            wdat_q <= wbs_dat_i;
        end
    end

    assign sys_idx = 4'(idx_q);
    assign wmask   = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
    assign wdata_m = wdat_q & wmask;

    // Read mux, evaluated on the pre-commit state.
    always_comb begin
        rd_val = '0;
        if (!pg_q) begin
            rd_val = regs_q[idx_q];
        end else begin
            case (sys_idx)
                4'd0:    rd_val = 32'(lock_q);
                4'd1:    rd_val = cycles_q;
                4'd2:    rd_val = {16'h0000, wrcnt_q};
                4'd3:    rd_val = {31'b0, err_q};
                default: rd_val = '0;
            endcase
        end
    end

    // Scratch registers, locks, write counter and error flag.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            // NOTE: the scratch array is reset because the bank must read
            // back all-zero after reset; it is small enough to live in flops.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            lock_q  <= '0;
            wrcnt_q <= '0;
            err_q   <= 1'b0;
        end else if (wr_commit) begin
            if (!pg_q) begin
                if (lock_q[idx_q]) begin
                    err_q <= 1'b1;              // blocked: nothing else changes
                end else begin
                    regs_q[idx_q] <= (regs_q[idx_q] & ~wmask) | wdata_m;
                    if (wrcnt_q != 16'hFFFF) wrcnt_q <= wrcnt_q + 16'd1;
                end
            end else begin
                case (sys_idx)
                    4'd0:    lock_q  <= lock_q | wdata_m[NUM_REGS-1:0];
                    4'd2:    wrcnt_q <= '0;
                    4'd3:    if (sel_q[0] && wdat_q[0]) err_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Free-running cycle counter; a write clears it on the same edge.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            cycles_q <= '0;
        end else if (wr_commit && pg_q && (sys_idx == 4'd1)) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    // Registered bus outputs; read data is forced to 0 outside ack.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= commit;
            rdata_q <= (commit && !we_q) ? rd_val : '0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;

endmodule

// File: tb/tb_debug_regs_bank.sv
// Testbench for debug_regs_bank: instance 0 with ACK_WAIT=0, instance 1 with
// ACK_WAIT=3, driven with directed bus transactions and hand-computed
// expected values.
module tb_debug_regs_bank;

    localparam logic [31:0] A_LOCK   = 32'h10;
    localparam logic [31:0] A_CYCLES = 32'h14;
    localparam logic [31:0] A_WRCNT  = 32'h18;
    localparam logic [31:0] A_STATUS = 32'h1C;

    logic             clk;
    logic             rst_n;
    logic [1:0]       cyc, stb, we, ack;
    logic [1:0][3:0]  sel;
    logic [1:0][31:0] dat_i, adr, dat_o;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    debug_regs_bank #(.NUM_REGS(4), .ACK_WAIT(0), .ADDR_LSB(2)) dut0 (
        .wb_clk_i (clk),      .wb_rstn_i(rst_n),
        .wbs_cyc_i(cyc[0]),   .wbs_stb_i(stb[0]),   .wbs_we_i (we[0]),
        .wbs_sel_i(sel[0]),   .wbs_dat_i(dat_i[0]), .wbs_adr_i(adr[0]),
        .wbs_ack_o(ack[0]),   .wbs_dat_o(dat_o[0])
    );

    debug_regs_bank #(.NUM_REGS(4), .ACK_WAIT(3), .ADDR_LSB(2)) dut1 (
        .wb_clk_i (clk),      .wb_rstn_i(rst_n),
        .wbs_cyc_i(cyc[1]),   .wbs_stb_i(stb[1]),   .wbs_we_i (we[1]),
        .wbs_sel_i(sel[1]),   .wbs_dat_i(dat_i[1]), .wbs_adr_i(adr[1]),
        .wbs_ack_o(ack[1]),   .wbs_dat_o(dat_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction; starts 1 time unit after a rising edge and returns
    // at the same phase. lat = edges from the accepting edge (1) to ack.
    // stamp = index of the edge that raised ack (the commit edge).
    task automatic xfer(input int u, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output int stamp);
        cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w;
        adr[u] = a; sel[u] = s; dat_i[u] = d;
        lat = 0;
        rd  = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ack[u]) begin
                lat = n;
                rd  = dat_o[u];
                break;
            end
        end
        stamp = edge_cnt;
        cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
        check("ack_seen", 32'(lat != 0), 32'd1);
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(ack[u]), 32'd0);
        check("dat_zero_after_ack", dat_o[u], 32'd0);
    endtask

    task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        int l, t;
        xfer(u, 1'b1, a, s, d, r, l, t);
    endtask

    task automatic rd_chk(input int u, input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int l, t;
        xfer(u, 1'b0, a, 4'hF, 32'd0, r, l, t);
        check(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r1, r2;
        int l1, s1, s2;
        logic seen;

        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0; sel = '0; dat_i = '0; adr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state.
        check("rst_ack0", 32'(ack[0]), 32'd0);
        check("rst_dat0", dat_o[0], 32'd0);
        xfer(0, 1'b0, 32'h0, 4'hF, 32'd0, r1, l1, s1);
        check("rst_reg0", r1, 32'd0);
        check("lat_wait0", 32'(l1), 32'd2);
        for (int i = 1; i < 4; i++) rd_chk(0, "rst_reg", 32'(i * 4), 32'd0);
        rd_chk(0, "rst_lock", A_LOCK, 32'd0);
        rd_chk(0, "rst_wrcnt", A_WRCNT, 32'd0);
        rd_chk(0, "rst_status", A_STATUS, 32'd0);

        // Byte lanes and write counting.
        wr(0, 32'h04, 32'hA5A5A5A5, 4'b1111);
        wr(0, 32'h04, 32'h0000FF00, 4'b0010);
        rd_chk(0, "lane_reg1", 32'h04, 32'hA5A5FFA5);
        rd_chk(0, "alias_reg1", 32'h104, 32'hA5A5FFA5);
        rd_chk(0, "wrcnt_2", A_WRCNT, 32'd2);
        wr(0, 32'h0C, 32'h01020304, 4'b1001);
        rd_chk(0, "lane_reg3", 32'h0C, 32'h01000004);
        rd_chk(0, "wrcnt_3", A_WRCNT, 32'd3);

        // Locks: bits above NUM_REGS read 0, sel masks the set.
        wr(0, A_LOCK, 32'hFFFFFFF2, 4'b1111);
        rd_chk(0, "lock_2", A_LOCK, 32'h2);
        wr(0, A_LOCK, 32'h1, 4'b0000);
        rd_chk(0, "lock_sel0", A_LOCK, 32'h2);
        wr(0, 32'h04, 32'h12345678, 4'b1111);
        rd_chk(0, "locked_reg1", 32'h04, 32'hA5A5FFA5);
        rd_chk(0, "err_set", A_STATUS, 32'd1);
        rd_chk(0, "wrcnt_blocked", A_WRCNT, 32'd3);
        wr(0, A_STATUS, 32'h1, 4'b0010);
        rd_chk(0, "err_sel1_keeps", A_STATUS, 32'd1);
        wr(0, A_STATUS, 32'h1, 4'b0001);
        rd_chk(0, "err_cleared", A_STATUS, 32'd0);
        wr(0, 32'h00, 32'h00000055, 4'b1111);
        rd_chk(0, "unlocked_reg0", 32'h00, 32'h55);
        rd_chk(0, "wrcnt_4", A_WRCNT, 32'd4);
        wr(0, A_WRCNT, 32'h0, 4'b0000);
        rd_chk(0, "wrcnt_clear", A_WRCNT, 32'd0);

        // Cycle counter: read delta equals edges between commit edges.
        xfer(0, 1'b0, A_CYCLES, 4'hF, 32'd0, r1, l1, s1);
        repeat (10) @(posedge clk);
        #1;
        xfer(0, 1'b0, A_CYCLES, 4'hF, 32'd0, r2, l1, s2);
        check("cycles_delta", r2 - r1, 32'(s2 - s1));
        check("cycles_delta_hand", 32'(s2 - s1), 32'd13);
        xfer(0, 1'b1, A_CYCLES, 4'b0000, 32'hFFFF, r1, l1, s1);
        xfer(0, 1'b0, A_CYCLES, 4'hF, 32'd0, r2, l1, s2);
        check("cycles_after_clear", r2, 32'(s2 - s1 - 1));

        // ACK_WAIT=3 instance: latency and abort.
        xfer(1, 1'b0, 32'h0, 4'hF, 32'd0, r1, l1, s1);
        check("w3_rst_reg0", r1, 32'd0);
        check("lat_wait3_rd", 32'(l1), 32'd5);
        xfer(1, 1'b1, 32'h0, 4'hF, 32'h11112222, r1, l1, s1);
        check("lat_wait3_wr", 32'(l1), 32'd5);

        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        adr[1] = 32'h0; sel[1] = 4'hF; dat_i[1] = 32'hFFFFFFFF;
        seen = 1'b0;
        repeat (2) @(posedge clk);
        #1 cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | ack[1];
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        rd_chk(1, "abort_reg0", 32'h0, 32'h11112222);
        rd_chk(1, "abort_wrcnt", A_WRCNT, 32'd1);

        // Reset in the middle of a waited write.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        adr[1] = 32'h4; sel[1] = 4'hF; dat_i[1] = 32'hCAFEF00D;
        seen = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            seen = seen | ack[1];
        end
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | ack[1];
        end
        check("rst_wait_no_ack", 32'(seen), 32'd0);
        xfer(1, 1'b0, 32'h4, 4'hF, 32'd0, r1, l1, s1);
        check("rst_wait_reg1", r1, 32'd0);
        check("rst_wait_lat", 32'(l1), 32'd5);
        rd_chk(1, "rst_wait_reg0", 32'h0, 32'd0);
        rd_chk(1, "rst_wait_wrcnt", A_WRCNT, 32'd0);
        rd_chk(0, "rst2_lock", A_LOCK, 32'd0);
        rd_chk(0, "rst2_reg1", 32'h04, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
